// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser followed by a four-state debounce FSM
// that turns a bouncing active-low push-button pin into a clean level on
// sys_clk. key_o only changes after DEBOUNCE_CYCLES consecutive samples that
// disagree with it; any agreeing sample restarts qualification from zero.
//
// Optional feature, enabled by defining KEY_DEBOUNCE_LONG_PRESS_EN:
//   a long-press detector that emits one key_long pulse per press once key_o
//   has been held at 0 long enough. Without the macro key_long is tied to 0.
//
// The FSM state is kept in r_state (type state_t) so checkers can bind to it.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter int CNT_W           = 26
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_raw,
    output logic key_o,
    output logic key_long
);

    typedef enum logic [1:0] {
        REL     = 2'd0,  // stable released, key_o = 1
        F_PRESS = 2'd1,  // filtering a press
        PRS     = 2'd2,  // stable pressed, key_o = 0
        F_REL   = 2'd3   // filtering a release
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Reject configurations the counter cannot represent.
    if (DEBOUNCE_CYCLES < 2 ||
        (CNT_W < 31 && (DEBOUNCE_CYCLES >= (1 << CNT_W) ||
                        LONG_CYCLES     >= (1 << CNT_W)))) begin : g_bad_param
        $error("key_debounce: DEBOUNCE_CYCLES must be >= 2 and both counts must fit in CNT_W bits");
    end

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_key_o;
    logic             w_key_o_nxt;

    // Two-flop synchroniser; both stages idle at the released level.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= key_raw;
            r_s2 <= r_s1;
        end
    end

    // FSM state, qualification counter and the debounced level register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= REL;
            r_cnt   <= '0;
            r_key_o <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_key_o <= w_key_o_nxt;
        end
    end

    // Next-state logic: a disagreeing sample opens a filter window, an agreeing
    // one inside the window is treated as a bounce and closes it again.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_key_o_nxt = r_key_o;
        case (r_state)
            REL: begin
                if (r_s2 != r_key_o) begin
                    w_state_nxt = F_PRESS;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            PRS: begin
                if (r_s2 != r_key_o) begin
                    w_state_nxt = F_REL;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            F_PRESS: begin
                if (r_s2 == r_key_o) begin
                    w_state_nxt = REL;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = PRS;
                    w_key_o_nxt = ~r_key_o;
                end else begin
                    w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
                end
            end
            F_REL: begin
                if (r_s2 == r_key_o) begin
                    w_state_nxt = PRS;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = REL;
                    w_key_o_nxt = ~r_key_o;
                end else begin
                    w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = REL;
            end
        endcase
    end

    assign key_o = r_key_o;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic [CNT_W-1:0] r_long_cnt;
    logic             r_long_fired;
    logic             r_long_hit;
    logic             r_key_long;

    // Long-press timer: counts while stably pressed, fires once per press and
    // re-arms only when the debounced level returns to released.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_long_cnt   <= '0;
            r_long_fired <= 1'b0;
            r_long_hit   <= 1'b0;
            r_key_long   <= 1'b0;
        end else begin
            if (r_state == PRS) begin
                if (r_long_cnt != CNT_MAX) begin
                    r_long_cnt <= r_long_cnt + CNT_ONE;
                end
            end else begin
                r_long_cnt <= '0;
            end

            r_long_hit <= 1'b0;
            if (r_key_o) begin
                r_long_fired <= 1'b0;
            end else if (r_state == PRS && !r_long_fired && r_long_cnt == LONG_LAST) begin
                r_long_fired <= 1'b1;
                r_long_hit   <= 1'b1;
            end

            r_key_long <= r_long_hit;
        end
    end

    assign key_long = r_key_long;
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed scenarios for key_debounce with DEBOUNCE_CYCLES=8
// and LONG_CYCLES=40. Each stimulus step pushes the output transitions it
// should cause (cycle number, which output, new value) into exp_q; a monitor
// watches key_o/key_long on the falling clock edge and pops one entry per
// observed transition. Cycle n is the value of cyc after the n-th rising edge.
module tb_key_debounce;

    localparam int D   = 8;
    localparam int L   = 40;
    localparam int CW  = 26;
    localparam int EW  = 26;  // {cycle[23:0], kind, value}

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic key_raw = 1'b1;
    logic key_o;
    logic key_long;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [EW-1:0] exp_q[$];
    logic          p_key  = 1'b1;
    logic          p_long = 1'b0;

    key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .CNT_W          (CW)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .key_raw  (key_raw),
        .key_o    (key_o),
        .key_long (key_long)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- scoreboard helpers ----------------
    function automatic logic [EW-1:0] mk_ev(input int c, input logic kind, input logic val);
        logic [23:0] c24;
        c24 = c[23:0];
        return {c24, kind, val};
    endfunction

    task automatic push_ev(input int c, input logic kind, input logic val);
        exp_q.push_back(mk_ev(c, kind, val));
    endtask

    task automatic see_ev(input logic [EW-1:0] got, input string name);
        logic [EW-1:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: unexpected change at cycle %0d (kind %0d, value %0d), required no change",
                     name, got[25:2], got[1], got[0]);
        end else begin
            exp = exp_q.pop_front();
            if (exp !== got) begin
                n_errors++;
                $display("FAIL %s: got cycle %0d kind %0d value %0d, required cycle %0d kind %0d value %0d",
                         name, got[25:2], got[1], got[0], exp[25:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (key_o !== p_key) begin
                see_ev(mk_ev(cyc, 1'b0, key_o), "key_o_edge");
                p_key = key_o;
            end
            if (key_long !== p_long) begin
                see_ev(mk_ev(cyc, 1'b1, key_long), "key_long_edge");
                p_long = key_long;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Change key_raw on a falling edge; e1 is the rising edge that captures it.
    task automatic set_raw(input logic v, output int e1);
        @(negedge clk);
        key_raw = v;
        e1 = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e;
        int e2;
        int f;

        // 1: reset with the key released; nothing may toggle afterwards.
        rst_n   = 1'b0;
        key_raw = 1'b1;
        idle(3);
        check_bit("reset_key_o", key_o, 1'b1);
        check_bit("reset_key_long", key_long, 1'b0);
        rst_n = 1'b1;
        idle(20);

        // 2: clean press then clean release; each lands on edge D+2 of its own
        //    capture, i.e. D+1 cycles after the capturing edge.
        set_raw(1'b0, e);
        push_ev(e + D + 1, 1'b0, 1'b0);
        idle(23);
        set_raw(1'b1, e);
        push_ev(e + D + 1, 1'b0, 1'b1);
        idle(19);

        // 3: 5 low, 3 high, then held low; only the final low qualifies.
        set_raw(1'b0, e);
        idle(4);
        set_raw(1'b1, e);
        idle(2);
        set_raw(1'b0, e);
        push_ev(e + D + 1, 1'b0, 1'b0);
        idle(23);
        set_raw(1'b1, e);
        push_ev(e + D + 1, 1'b0, 1'b1);
        idle(19);

        // 4a: 7-cycle low pulse is too short to reach key_o.
        set_raw(1'b0, e);
        idle(6);
        set_raw(1'b1, e);
        idle(19);

        // 4b: 8-cycle low pulse just qualifies; key_o falls on edge 10 of the
        //     pulse and comes back on edge 18 (edge 10 of the release).
        set_raw(1'b0, e);
        push_ev(e + D + 1, 1'b0, 1'b0);
        idle(7);
        set_raw(1'b1, e2);
        push_ev(e2 + D + 1, 1'b0, 1'b1);
        idle(19);

        // 5: reset while the press filter has counted to 5, key held low.
        set_raw(1'b0, e);
        idle(7);
        rst_n = 1'b0;
        #1;
        check_bit("midfilter_reset_key_o", key_o, 1'b1);
        check_bit("midfilter_reset_key_long", key_long, 1'b0);
        idle(2);
        rst_n = 1'b1;
        e = cyc + 1;
        push_ev(e + D + 1, 1'b0, 1'b0);
        idle(23);
        set_raw(1'b1, e);
        push_ev(e + D + 1, 1'b0, 1'b1);
        idle(19);

        // 6: long hold, 100 cycles past the debounced fall.
        set_raw(1'b0, e);
        f = e + D + 1;
        push_ev(f, 1'b0, 1'b0);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        push_ev(f + L + 1, 1'b1, 1'b1);
        push_ev(f + L + 2, 1'b1, 1'b0);
`endif
        idle(D + 1 + 100);
        set_raw(1'b1, e);
        push_ev(e + D + 1, 1'b0, 1'b1);
        idle(20);

        // Every expected transition must have been seen.
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d expected transitions never seen, required 0",
                     exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
